// File: rtl/sort_arb.sv
// sort_arb: shares one packet sort engine among N_PORTS requesters.
//
// A requester presenting a start-of-packet beat in IDLE is granted
// round-robin. Its packet is streamed into the sorter (FEED), and the
// sorted packet coming back is routed to that same requester (RETURN).
// A watchdog abandons RETURN if the sorter stays silent too long.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no owner; pick next sop requester, flush orphan non-sop beats
// FEED   | owner's beats pass straight through to the sorter input
// RETURN | sorter output passes straight through to the owner's response
//
// Ports
//   clk_i, rst_i              clock, async active-high reset
//   req_*                     N_PORTS packet request streams (data packed)
//   srt_snk_*                 stream into the sort engine
//   srt_src_*                 stream out of the sort engine
//   rsp_*                     shared response data, per-port valid/ready
//   owner_o, busy_o           current owner, engine in use
//   timeout_o, drop_o         watchdog expiry pulse, orphan beat flush pulse
module sort_arb #(
  parameter int DWIDTH  = 8,
  parameter int N_PORTS = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_PORTS*DWIDTH-1:0]    req_data_i,
  input  logic [N_PORTS-1:0]           req_startofpacket_i,
  input  logic [N_PORTS-1:0]           req_endofpacket_i,
  input  logic [N_PORTS-1:0]           req_valid_i,
  output logic [N_PORTS-1:0]           req_ready_o,
  output logic [DWIDTH-1:0]            srt_snk_data_o,
  output logic                         srt_snk_startofpacket_o,
  output logic                         srt_snk_endofpacket_o,
  output logic                         srt_snk_valid_o,
  input  logic                         srt_snk_ready_i,
  input  logic [DWIDTH-1:0]            srt_src_data_i,
  input  logic                         srt_src_startofpacket_i,
  input  logic                         srt_src_endofpacket_i,
  input  logic                         srt_src_valid_i,
  output logic                         srt_src_ready_o,
  output logic [DWIDTH-1:0]            rsp_data_o,
  output logic                         rsp_startofpacket_o,
  output logic                         rsp_endofpacket_o,
  output logic [N_PORTS-1:0]           rsp_valid_o,
  input  logic [N_PORTS-1:0]           rsp_ready_i,
  output logic [$clog2(N_PORTS)-1:0]   owner_o,
  output logic                         busy_o,
  output logic                         timeout_o,
  output logic                         drop_o
);

  localparam int PW = $clog2(N_PORTS);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);
  localparam logic [PW-1:0] LAST_PORT = PW'(N_PORTS - 1);

  typedef enum logic [1:0] {IDLE, FEED, RETURN} state_e;

  state_e          state_q;
  logic [PW-1:0]   owner_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [WW-1:0]   wd_q;
  logic            timeout_q;
  logic            drop_q;

  logic [DWIDTH-1:0] data_arr [N_PORTS];
  logic [N_PORTS-1:0] sop_req;
  logic [N_PORTS-1:0] flush;
  logic               grant_vld;
  logic [PW-1:0]      grant_idx;
  logic [PW-1:0]      scan_port;
  int                 scan_idx;
  logic               in_idle, in_feed, in_return;
  logic               own_valid, own_sop, own_eop;
  logic               feed_last, ret_last;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
    assign data_arr[gi] = req_data_i[gi*DWIDTH +: DWIDTH];
  end

  assign in_idle   = (state_q == IDLE);
  assign in_feed   = (state_q == FEED);
  assign in_return = (state_q == RETURN);

  assign sop_req = req_valid_i & req_startofpacket_i;
  // IDLE is also the reset state, so the flush path needs its own reset gate.
  assign flush   = (in_idle && !rst_i) ? (req_valid_i & ~req_startofpacket_i) : '0;

  // Scan from the far end back toward rr_ptr so the nearest requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    scan_port = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= N_PORTS) scan_idx = scan_idx - N_PORTS;
      scan_port = PW'(scan_idx);
      if (sop_req[scan_port]) begin
        grant_vld = 1'b1;
        grant_idx = scan_port;
      end
    end
  end

  assign own_valid = req_valid_i[owner_q];
  assign own_sop   = req_startofpacket_i[owner_q];
  assign own_eop   = req_endofpacket_i[owner_q];

  assign srt_snk_data_o          = data_arr[owner_q];
  assign srt_snk_startofpacket_o = own_sop;
  assign srt_snk_endofpacket_o   = own_eop;
  assign srt_snk_valid_o         = in_feed & own_valid;

  always_comb begin
    req_ready_o = flush;
    if (in_feed) req_ready_o[owner_q] = srt_snk_ready_i;
  end

  assign feed_last = in_feed & own_valid & srt_snk_ready_i & own_eop;

  assign rsp_data_o          = srt_src_data_i;
  assign rsp_startofpacket_o = srt_src_startofpacket_i;
  assign rsp_endofpacket_o   = srt_src_endofpacket_i;

  always_comb begin
    rsp_valid_o = '0;
    if (in_return) rsp_valid_o[owner_q] = srt_src_valid_i;
  end

  assign srt_src_ready_o = in_return & rsp_ready_i[owner_q];
  assign ret_last        = srt_src_valid_i & srt_src_ready_o & srt_src_endofpacket_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      drop_q    <= |flush;
      case (state_q)
        IDLE: begin
          wd_q <= '0;
          if (grant_vld) begin
            state_q  <= FEED;
            owner_q  <= grant_idx;
            rr_ptr_q <= (grant_idx == LAST_PORT) ? '0 : grant_idx + PW'(1);
          end
        end
        FEED: begin
          if (feed_last) begin
            state_q <= RETURN;
            wd_q    <= '0;
          end
        end
        RETURN: begin
          if (ret_last) begin
            state_q <= IDLE;
            wd_q    <= '0;
          end else if (srt_src_valid_i) begin
            // A sorter that is producing but back-pressured is not stuck.
            wd_q <= '0;
          end else if (wd_q >= WD_LAST) begin
            state_q   <= IDLE;
            timeout_q <= 1'b1;
            wd_q      <= '0;
          end else if (wd_q != '1) begin
            wd_q <= wd_q + WW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign owner_o   = owner_q;
  assign busy_o    = !in_idle;
  assign timeout_o = timeout_q;
  assign drop_o    = drop_q;

endmodule
